// File: rtl/wiegand26_frame_decoder.sv
// Wiegand-26 frame decoder: detects completed frames, checks both parity bits,
// splits facility/card and queues results in a show-ahead FIFO for the host.
module wiegand26_frame_decoder #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SETTLE_CYC = 3,
    parameter int unsigned PASS_BAD   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [25:0] wg_data,
    input  logic        wg_busy,
    input  logic        rd_en,
    input  logic        clr_stat,
    output logic [24:0] rd_data,
    output logic        rd_empty,
    output logic [4:0]  fifo_level,
    output logic        irq,
    output logic [7:0]  err_cnt,
    output logic        ovf
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {StIdle, StSettle, StCheck, StPush} state_e;

    state_e          state;
    logic [CW-1:0]   settle_cnt;
    logic [25:0]     cap;
    logic            bad_q;
    logic [7:0]      fac_q;
    logic [15:0]     card_q;

    logic            busy_s1, busy_s2, busy_prev;
    logic            frame_done;

    logic [24:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop, full, wr_en;

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_s1   <= 1'b0;
            busy_s2   <= 1'b0;
            busy_prev <= 1'b0;
        end else begin
            busy_s1   <= wg_busy;
            busy_s2   <= busy_s1;
            busy_prev <= busy_s2;
        end
    end

    assign frame_done = !busy_s2 && busy_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            settle_cnt <= '0;
            cap        <= '0;
            bad_q      <= 1'b0;
            fac_q      <= '0;
            card_q     <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (frame_done) begin
                        settle_cnt <= CW'(SETTLE_CYC - 1);
                        state      <= StSettle;
                    end
                end
                StSettle: begin
                    if (settle_cnt == '0) begin
                        cap   <= wg_data;
                        state <= StCheck;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                StCheck: begin
                    // Even parity over bits 25..13, odd parity over bits 12..0
                    bad_q  <= !((~^cap[25:13]) && (^cap[12:0]));
                    fac_q  <= cap[24:17];
                    card_q <= cap[16:1];
                    state  <= StPush;
                end
                StPush: begin
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign push  = (state == StPush) && (!bad_q || (PASS_BAD != 0));
    assign pop   = rd_en && (fifo_level != 5'd0);
    assign full  = (fifo_level == 5'(FIFO_DEPTH));
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            ovf        <= 1'b0;
            err_cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + {4'd0, wr_en} - {4'd0, pop};
            if (clr_stat) begin
                ovf     <= 1'b0;
                err_cnt <= '0;
            end else begin
                if (push && full && !pop) ovf <= 1'b1;
                if ((state == StPush) && bad_q && (err_cnt != 8'hFF)) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {bad_q, fac_q, card_q};
    end

    assign rd_empty = (fifo_level == 5'd0);
    assign irq      = !rd_empty;
    assign rd_data  = rd_empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_wiegand26_frame_decoder.sv
// Directed bench for wiegand26_frame_decoder; a second instance covers PASS_BAD=1.
module tb_wiegand26_frame_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [25:0] wg_data = '0;
    logic        wg_busy = 1'b0;
    logic        rd_en = 1'b0;
    logic        clr_stat = 1'b0;

    logic [24:0] rd_data, pb_rd_data;
    logic        rd_empty, pb_rd_empty;
    logic [4:0]  fifo_level, pb_fifo_level;
    logic        irq, pb_irq;
    logic [7:0]  err_cnt, pb_err_cnt;
    logic        ovf, pb_ovf;

    int checks = 0;
    int errors = 0;
    logic [24:0] q[$];

    always #5 clk = ~clk;

    wiegand26_frame_decoder #(.FIFO_DEPTH(4), .SETTLE_CYC(3), .PASS_BAD(0)) dut (
        .clk(clk), .rst(rst), .wg_data(wg_data), .wg_busy(wg_busy), .rd_en(rd_en),
        .clr_stat(clr_stat), .rd_data(rd_data), .rd_empty(rd_empty),
        .fifo_level(fifo_level), .irq(irq), .err_cnt(err_cnt), .ovf(ovf)
    );

    wiegand26_frame_decoder #(.FIFO_DEPTH(4), .SETTLE_CYC(3), .PASS_BAD(1)) dut_pb (
        .clk(clk), .rst(rst), .wg_data(wg_data), .wg_busy(wg_busy), .rd_en(rd_en),
        .clr_stat(clr_stat), .rd_data(pb_rd_data), .rd_empty(pb_rd_empty),
        .fifo_level(pb_fifo_level), .irq(pb_irq), .err_cnt(pb_err_cnt), .ovf(pb_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [25:0] mk(input logic [7:0] fac, input logic [15:0] card);
        logic [23:0] body;
        body = {fac, card};
        return {^body[23:12], body, ~^body[11:0]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one frame; busy falls at N0. With pop_in_push, rd_en is high for the
    // 7th..8th negedge window, i.e. exactly the PUSH cycle.
    task automatic send_frame(input logic [25:0] d, input bit pop_in_push,
                              output logic [24:0] head7, output logic empty7,
                              output logic empty8);
        @(negedge clk);
        wg_data = d;
        wg_busy = 1'b1;
        repeat (3) @(negedge clk);
        wg_busy = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 7) begin
                head7  = rd_data;
                empty7 = rd_empty;
                rd_en  = pop_in_push;
            end else begin
                rd_en = 1'b0;
            end
            if (k == 8) empty8 = rd_empty;
        end
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        logic [24:0] h;
        logic        e7, e8;

        // Reset values and a good frame with its exact latency
        do_reset();
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_empty", 32'(rd_empty), 32'd1);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        send_frame(26'h02468AC, 1'b0, h, e7, e8);
        check("lat_empty_before", 32'(e7), 32'd1);
        check("lat_empty_after", 32'(e8), 32'd0);
        check("good_rd_data", 32'(rd_data), 32'h0123456);
        check("good_irq", 32'(irq), 32'd1);
        check("good_level", 32'(fifo_level), 32'd1);
        check("good_err", 32'(err_cnt), 32'd0);
        pop_one();
        check("pop_empty", 32'(rd_empty), 32'd1);
        check("pop_irq", 32'(irq), 32'd0);

        // Even-parity error
        do_reset();
        send_frame(26'h22468AC, 1'b0, h, e7, e8);
        check("pe_level", 32'(fifo_level), 32'd0);
        check("pe_err", 32'(err_cnt), 32'd1);
        check("pe_pb_rd_data", 32'(pb_rd_data), 32'h1123456);
        check("pe_pb_err", 32'(pb_err_cnt), 32'd1);

        // Odd-parity error, then saturation and clear
        do_reset();
        send_frame(26'h02468AD, 1'b0, h, e7, e8);
        check("po_empty", 32'(rd_empty), 32'd1);
        check("po_err", 32'(err_cnt), 32'd1);
        check("po_pb_rd_data", 32'(pb_rd_data), 32'h1123456);
        for (int i = 0; i < 259; i++) send_frame(26'h02468AD, 1'b0, h, e7, e8);
        check("sat_err", 32'(err_cnt), 32'd255);
        check("sat_pb_err", 32'(pb_err_cnt), 32'd255);
        clr_stat = 1'b1;
        @(negedge clk);
        clr_stat = 1'b0;
        check("clr_err", 32'(err_cnt), 32'd0);

        // Overflow: five frames into a depth-4 FIFO
        do_reset();
        for (int i = 1; i <= 5; i++) send_frame(mk(8'hA5, 16'(i)), 1'b0, h, e7, e8);
        check("ovf_level", 32'(fifo_level), 32'd4);
        check("ovf_flag", 32'(ovf), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check("ovf_order", 32'(rd_data), {7'd0, 1'b0, 8'hA5, 16'(i)});
            pop_one();
        end
        check("ovf_drained", 32'(rd_empty), 32'd1);
        clr_stat = 1'b1;
        @(negedge clk);
        clr_stat = 1'b0;
        check("ovf_clr", 32'(ovf), 32'd0);

        // Full with a pop in the PUSH cycle, repeated to wrap the pointers
        do_reset();
        q.delete();
        for (int i = 0; i < 4; i++) begin
            send_frame(mk(8'h3C, 16'h0100 + 16'(i)), 1'b0, h, e7, e8);
            q.push_back({1'b0, 8'h3C, 16'h0100 + 16'(i)});
        end
        for (int i = 4; i < 15; i++) begin
            send_frame(mk(8'h3C, 16'h0100 + 16'(i)), 1'b1, h, e7, e8);
            check("fp_head", 32'(h), 32'(q[0]));
            void'(q.pop_front());
            q.push_back({1'b0, 8'h3C, 16'h0100 + 16'(i)});
            check("fp_level", 32'(fifo_level), 32'd4);
            check("fp_ovf", 32'(ovf), 32'd0);
        end
        while (q.size() > 0) begin
            check("fp_drain", 32'(rd_data), 32'(q[0]));
            void'(q.pop_front());
            pop_one();
        end
        check("fp_empty", 32'(rd_empty), 32'd1);

        // Reset asserted during SETTLE with two entries queued
        do_reset();
        send_frame(mk(8'h01, 16'h1111), 1'b0, h, e7, e8);
        send_frame(mk(8'h02, 16'h2222), 1'b0, h, e7, e8);
        check("mid_level_pre", 32'(fifo_level), 32'd2);
        @(negedge clk);
        wg_data = mk(8'h03, 16'h3333);
        wg_busy = 1'b1;
        repeat (3) @(negedge clk);
        wg_busy = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rd_data", 32'(rd_data), 32'h0);
        check("mid_empty", 32'(rd_empty), 32'd1);
        check("mid_level", 32'(fifo_level), 32'd0);
        check("mid_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_discard", 32'(rd_empty), 32'd1);
        send_frame(mk(8'h77, 16'hBEEF), 1'b0, h, e7, e8);
        check("mid_next", 32'(rd_data), {7'd0, 1'b0, 8'h77, 16'hBEEF});
        check("mid_next_lvl", 32'(fifo_level), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
